// File: rtl/score_overlay_if.sv
// Pixel-side bundle shared by the VGA timing generator / pixel mixer and the
// score overlay: raster position and qualifiers in, one overlay pixel out.
interface score_overlay_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       enable;
  logic       frame_start;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       layer;

  // Raster side: drives position/qualifiers, receives the overlay pixel.
  modport master (
    output hcount, vcount, enable, frame_start,
    input  red, green, blue, layer
  );

  // Overlay side: consumes position/qualifiers, produces the overlay pixel.
  modport slave (
    input  hcount, vcount, enable, frame_start,
    output red, green, blue, layer
  );
endinterface

// File: rtl/score_overlay.sv
// Two-player score overlay for the 640x480 pong pipeline.
// Holds both scores, runs the IDLE/PLAY/WON game FSM, and draws each score as a
// vertical stack of bar segments at the screen edges. In WON the winner's stack
// blinks. The pixel output is registered (one cycle behind hcount/vcount).
// Optional feature macro: SCORE_FLASH_EN -- a freshly scored segment is drawn
// yellow for FLASH_FRAMES frames before turning white.
module score_overlay #(
  parameter int MAX_SCORE    = 5,
  parameter int SCORE_W      = 4,
  parameter int SEG_W        = 30,
  parameter int SEG_H        = 60,
  parameter int SEG_PITCH    = 76,
  parameter int SEG_Y0       = 11,
  parameter int P1_X0        = 11,
  parameter int P2_X0        = 601,
  parameter int BLINK_FRAMES = 16,
  parameter int FLASH_FRAMES = 30
) (
  input  logic               clock,
  input  logic               reset,
  score_overlay_if.slave     pix,
  input  logic               menu,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic               winner
);

  // Reject parameter sets that would make the stacks or counters meaningless.
  if (MAX_SCORE < 1 || MAX_SCORE > 15) begin : g_bad_max
    $error("score_overlay: MAX_SCORE must be 1..15");
  end
  if ((2 ** SCORE_W) <= MAX_SCORE) begin : g_bad_width
    $error("score_overlay: SCORE_W too narrow for MAX_SCORE");
  end
  if (SEG_PITCH < SEG_H) begin : g_bad_pitch
    $error("score_overlay: SEG_PITCH must be >= SEG_H");
  end
  if (BLINK_FRAMES < 1 || FLASH_FRAMES < 1) begin : g_bad_frames
    $error("score_overlay: BLINK_FRAMES and FLASH_FRAMES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WON  = 2'd2
  } state_t;

  localparam int                 BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SCORE_W-1:0] MAX_S   = SCORE_W'(MAX_SCORE);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  state_t             state_r;
  logic [SCORE_W-1:0] score1_r;
  logic [SCORE_W-1:0] score2_r;
  logic               game_over_r;
  logic               winner_r;
  logic               blink_phase_r;
  logic [BLINK_W-1:0] blink_cnt_r;

  logic               accept1_s;
  logic               accept2_s;
  logic [SCORE_W-1:0] next1_s;
  logic [SCORE_W-1:0] next2_s;
  logic               flash_on1_s;
  logic               flash_on2_s;

  logic [2:0]         red_r;
  logic [2:0]         green_r;
  logic [1:0]         blue_r;
  logic               layer_r;
  logic [2:0]         red_s;
  logic [2:0]         green_s;
  logic [1:0]         blue_s;
  logic               layer_s;

  // True when column h falls inside the stack whose left column is x0.
  function automatic logic in_cols(input logic [9:0] h, input int x0);
    return (int'(h) >= x0) && (int'(h) <= x0 + SEG_W - 1);
  endfunction

  // True when row v falls inside segment k of either stack.
  function automatic logic in_seg_row(input logic [9:0] v, input int k);
    int top;
    top = SEG_Y0 + k * SEG_PITCH;
    return (int'(v) >= top) && (int'(v) <= top + SEG_H - 1);
  endfunction

  // Point acceptance: only in PLAY, never while the menu is up, never past the cap.
  always_comb begin
    accept1_s = (state_r == S_PLAY) && !menu && point_p1 && (score1_r < MAX_S);
    accept2_s = (state_r == S_PLAY) && !menu && point_p2 && (score2_r < MAX_S);
    next1_s   = accept1_s ? (score1_r + SCORE_W'(1)) : score1_r;
    next2_s   = accept2_s ? (score2_r + SCORE_W'(1)) : score2_r;
  end

  // Game FSM: scores, win detection with player-1 priority, and blink timing in WON.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= S_IDLE;
      score1_r      <= '0;
      score2_r      <= '0;
      game_over_r   <= 1'b0;
      winner_r      <= 1'b0;
      blink_phase_r <= 1'b0;
      blink_cnt_r   <= '0;
    end else if (menu) begin
      state_r       <= S_IDLE;
      score1_r      <= '0;
      score2_r      <= '0;
      game_over_r   <= 1'b0;
      winner_r      <= 1'b0;
      blink_phase_r <= 1'b0;
      blink_cnt_r   <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= S_PLAY;
        end
        S_PLAY: begin
          score1_r <= next1_s;
          score2_r <= next2_s;
          if ((next1_s == MAX_S) || (next2_s == MAX_S)) begin
            state_r       <= S_WON;
            game_over_r   <= 1'b1;
            winner_r      <= (next1_s == MAX_S) ? 1'b0 : 1'b1;
            blink_phase_r <= 1'b0;
            blink_cnt_r   <= '0;
          end else begin
            state_r <= S_PLAY;
          end
        end
        S_WON: begin
          if (pix.frame_start) begin
            if (blink_cnt_r == BLINK_LAST) begin
              blink_cnt_r   <= '0;
              blink_phase_r <= ~blink_phase_r;
            end else begin
              blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
            end
          end else begin
            blink_cnt_r <= blink_cnt_r;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SCORE_FLASH_EN
  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

  logic [FLASH_W-1:0] flash1_r;
  logic [FLASH_W-1:0] flash2_r;

  // Next flash count: reload on an accepted point, otherwise count frames down to zero.
  function automatic logic [FLASH_W-1:0] flash_next(input logic [FLASH_W-1:0] cnt,
                                                     input logic hit, input logic fs);
    if (hit) begin
      return FLASH_W'(FLASH_FRAMES);
    end else if (fs && (cnt != '0)) begin
      return cnt - FLASH_W'(1);
    end else begin
      return cnt;
    end
  endfunction

  // Per-player highlight timers for the newest segment.
  always_ff @(posedge clock) begin
    if (reset || menu) begin
      flash1_r <= '0;
      flash2_r <= '0;
    end else begin
      flash1_r <= flash_next(flash1_r, accept1_s, pix.frame_start);
      flash2_r <= flash_next(flash2_r, accept2_s, pix.frame_start);
    end
  end

  assign flash_on1_s = (flash1_r != '0);
  assign flash_on2_s = (flash2_r != '0);
`else
  assign flash_on1_s = 1'b0;
  assign flash_on2_s = 1'b0;
`endif

  // Pixel decode: which stack segment (if any) covers this pixel, and its colour.
  always_comb begin
    logic lit1;
    logic lit2;
    logic new1;
    logic new2;
    logic blank1;
    logic blank2;
    lit1 = 1'b0;
    lit2 = 1'b0;
    new1 = 1'b0;
    new2 = 1'b0;
    for (int k = 0; k < MAX_SCORE; k++) begin
      lit1 = lit1 | (in_seg_row(pix.vcount, k) && (int'(score1_r) > k));
      lit2 = lit2 | (in_seg_row(pix.vcount, k) && (int'(score2_r) > k));
      new1 = new1 | (in_seg_row(pix.vcount, k) && (int'(score1_r) == k + 1));
      new2 = new2 | (in_seg_row(pix.vcount, k) && (int'(score2_r) == k + 1));
    end
    lit1   = lit1 && in_cols(pix.hcount, P1_X0);
    lit2   = lit2 && in_cols(pix.hcount, P2_X0);
    blank1 = (state_r == S_WON) && blink_phase_r && (winner_r == 1'b0);
    blank2 = (state_r == S_WON) && blink_phase_r && (winner_r == 1'b1);

    red_s   = 3'd0;
    green_s = 3'd0;
    blue_s  = 2'd0;
    layer_s = 1'b0;
    if (!pix.enable) begin
      layer_s = 1'b0;
    end else if (lit1 && !blank1) begin
      red_s   = 3'd7;
      green_s = 3'd7;
      blue_s  = (new1 && flash_on1_s) ? 2'd0 : 2'd3;
      layer_s = 1'b1;
    end else if (lit2 && !blank2) begin
      red_s   = 3'd7;
      green_s = 3'd7;
      blue_s  = (new2 && flash_on2_s) ? 2'd0 : 2'd3;
      layer_s = 1'b1;
    end else begin
      layer_s = 1'b0;
    end
  end

  // Register the pixel so the mixer sees a clean one-cycle-latency layer.
  always_ff @(posedge clock) begin
    if (reset) begin
      red_r   <= 3'd0;
      green_r <= 3'd0;
      blue_r  <= 2'd0;
      layer_r <= 1'b0;
    end else begin
      red_r   <= red_s;
      green_r <= green_s;
      blue_r  <= blue_s;
      layer_r <= layer_s;
    end
  end

  assign pix.red   = red_r;
  assign pix.green = green_r;
  assign pix.blue  = blue_r;
  assign pix.layer = layer_r;
  assign score1    = score1_r;
  assign score2    = score2_r;
  assign game_over = game_over_r;
  assign winner    = winner_r;

endmodule

// File: tb/tb_score_overlay.sv
// Self-checking bench for score_overlay: directed game sequences, with pixel
// expectations queued as each probe is driven and compared when the registered
// pixel appears one cycle later.
module tb_score_overlay;
  logic       clock = 1'b0;
  logic       reset;
  logic       menu;
  logic       point_p1;
  logic       point_p2;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       game_over;
  logic       winner;

  localparam logic [8:0] PX_BLACK  = 9'h000;
  localparam logic [8:0] PX_WHITE  = 9'h1FF;
  localparam logic [8:0] PX_YELLOW = 9'h1FC;
`ifdef SCORE_FLASH_EN
  localparam logic [8:0] PX_NEWEST = PX_YELLOW;
`else
  localparam logic [8:0] PX_NEWEST = PX_WHITE;
`endif

  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];

  always #5 clock = ~clock;

  score_overlay_if pix_if();

  score_overlay dut (
    .clock     (clock),
    .reset     (reset),
    .pix       (pix_if),
    .menu      (menu),
    .point_p1  (point_p1),
    .point_p2  (point_p2),
    .score1    (score1),
    .score2    (score2),
    .game_over (game_over),
    .winner    (winner)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one raster position, queue its expected pixel, compare one cycle later.
  task automatic probe(input string tag, input int h, input int v, input logic en,
                       input logic [8:0] e);
    logic [8:0] got;
    pix_if.hcount = 10'(h);
    pix_if.vcount = 10'(v);
    pix_if.enable = en;
    exp_q.push_back(e);
    @(negedge clock);
    pix_if.enable = 1'b0;
    got = {pix_if.layer, pix_if.red, pix_if.green, pix_if.blue};
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue_empty"}, 1, 0);
    end else begin
      check_val(tag, int'(got), int'(exp_q.pop_front()));
    end
  endtask

  task automatic pulse(input logic p1, input logic p2);
    point_p1 = p1;
    point_p2 = p2;
    @(negedge clock);
    point_p1 = 1'b0;
    point_p2 = 1'b0;
  endtask

  task automatic frame();
    pix_if.frame_start = 1'b1;
    @(negedge clock);
    pix_if.frame_start = 1'b0;
  endtask

  task automatic status(input string tag, input int s1, input int s2, input int go,
                        input int w);
    check_val({tag, "_score1"}, int'(score1), s1);
    check_val({tag, "_score2"}, int'(score2), s2);
    check_val({tag, "_game_over"}, int'(game_over), go);
    check_val({tag, "_winner"}, int'(winner), w);
  endtask

  initial begin
    reset              = 1'b1;
    menu               = 1'b0;
    point_p1           = 1'b1;
    point_p2           = 1'b0;
    pix_if.hcount      = 10'd20;
    pix_if.vcount      = 10'd11;
    pix_if.enable      = 1'b1;
    pix_if.frame_start = 1'b0;
    repeat (2) @(negedge clock);
    check_val("reset_pixel", int'({pix_if.layer, pix_if.red, pix_if.green, pix_if.blue}), 0);
    status("reset", 0, 0, 0, 0);

    // Menu up, then leave the menu with a point in the same cycle (still IDLE).
    point_p1      = 1'b0;
    pix_if.enable = 1'b0;
    reset         = 1'b0;
    menu          = 1'b1;
    @(negedge clock);
    pulse(1'b1, 1'b0);
    status("menu_point", 0, 0, 0, 0);
    menu = 1'b0;
    pulse(1'b1, 1'b0);
    status("idle_point", 0, 0, 0, 0);

    // Three player-1 points and one player-2 point in PLAY.
    repeat (3) pulse(1'b1, 1'b0);
    status("three_p1", 3, 0, 0, 0);
    probe("p1_seg2_lit", 20, 11 + 2 * 76, 1'b1, PX_NEWEST);
    probe("p1_seg3_dark", 20, 11 + 3 * 76, 1'b1, PX_BLACK);
    probe("p1_corner_tl", 11, 11, 1'b1, PX_WHITE);
    probe("p1_left_out", 10, 11, 1'b1, PX_BLACK);
    probe("p1_right_in", 40, 11, 1'b1, PX_WHITE);
    probe("p1_right_out", 41, 11, 1'b1, PX_BLACK);
    probe("p1_bottom_in", 20, 70, 1'b1, PX_WHITE);
    probe("p1_gap_row", 20, 71, 1'b1, PX_BLACK);
    probe("p1_top_out", 20, 10, 1'b1, PX_BLACK);
    probe("enable_low", 20, 11, 1'b0, PX_BLACK);
    probe("p2_empty", 610, 11, 1'b1, PX_BLACK);
    pulse(1'b0, 1'b1);
    status("one_p2", 3, 1, 0, 0);
    probe("p2_left_in", 601, 11, 1'b1, PX_NEWEST);
    probe("p2_left_out", 600, 11, 1'b1, PX_BLACK);
    probe("p2_right_in", 630, 11, 1'b1, PX_NEWEST);
    probe("p2_right_out", 631, 11, 1'b1, PX_BLACK);
    probe("p2_seg1_dark", 610, 87, 1'b1, PX_BLACK);

    // Menu with a simultaneous point: cleared, no increment.
    menu = 1'b1;
    pulse(1'b0, 1'b1);
    status("menu_clear", 0, 0, 0, 0);
    menu = 1'b0;
    @(negedge clock);

    // Both players to 4, then a simultaneous winning point: player 1 wins.
    repeat (4) pulse(1'b1, 1'b1);
    status("both_four", 4, 4, 0, 0);
    pulse(1'b1, 1'b1);
    status("tie_win", 5, 5, 1, 0);
    pulse(1'b1, 1'b1);
    pulse(1'b0, 1'b1);
    status("won_saturate", 5, 5, 1, 0);
    probe("won_p1_seg0", 20, 11, 1'b1, PX_WHITE);

    // Back to menu, then player 2 wins 5-2.
    menu = 1'b1;
    @(negedge clock);
    status("menu_from_won", 0, 0, 0, 0);
    menu = 1'b0;
    @(negedge clock);
    repeat (2) pulse(1'b1, 1'b0);
    repeat (5) pulse(1'b0, 1'b1);
    status("p2_wins", 2, 5, 1, 1);

    // Winner stack blinks: blank after pulses 16..31, visible again from 32.
    for (int n = 1; n <= 32; n++) begin
      frame();
      if (n == 15 || n == 16 || n == 31 || n == 32) begin
        probe($sformatf("blink_p2_f%0d", n), 610, 11, 1'b1,
              (n >= 16 && n <= 31) ? PX_BLACK : PX_WHITE);
      end
      if (n == 16) begin
        probe("blink_p1_steady", 20, 11, 1'b1, PX_WHITE);
      end
    end
    status("after_blink", 2, 5, 1, 1);

`ifdef SCORE_FLASH_EN
    // Newest segment highlight lasts FLASH_FRAMES frame pulses.
    menu = 1'b1;
    @(negedge clock);
    menu = 1'b0;
    @(negedge clock);
    pulse(1'b0, 1'b1);
    probe("flash_start", 610, 11, 1'b1, PX_YELLOW);
    repeat (29) frame();
    probe("flash_f29", 610, 11, 1'b1, PX_YELLOW);
    frame();
    probe("flash_f30", 610, 11, 1'b1, PX_WHITE);
`endif

    check_val("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
